cordic_pipe_param: RTL and testbench

- Parametrised successor of the fixed 16-bit, 7-stage pipelined shift-add CORDIC array.
- Configurable data width and stage count.
- Per-sample mode: rotation (external direction bits) or vectoring (directions derived from the sign of YM).
- Valid/ready backpressure across the whole pipeline, optional saturation with an overflow flag, and a tag carried through the pipe.
- Sits between the index/quadrant pre-processor and the output post-scaler.

---
 rtl/cordic_pipe_param.sv | 162 ++++++++++++++++
 tb/tb_cordic_pipe_param.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_pipe_param.sv
// Parametrised pipelined shift-add CORDIC array with per-sample rotation/vectoring mode,
// global valid/ready stall, optional saturation and a side-band tag.
module cordic_pipe_param #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 7,
    parameter int unsigned TAG_W  = 10,
    parameter int unsigned SAT    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mode,
    input  logic [WIDTH-1:0]  xm,
    input  logic [WIDTH-1:0]  ym,
    input  logic [WIDTH-1:0]  xr,
    input  logic [WIDTH-1:0]  yr,
    input  logic [STAGES-1:0] dir_in,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  x_out,
    output logic [WIDTH-1:0]  y_out,
    output logic [WIDTH-1:0]  xr_out,
    output logic [WIDTH-1:0]  yr_out,
    output logic [STAGES-1:0] dir_out,
    output logic [TAG_W-1:0]  tag_out,
    output logic              ovf_out
);

    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    // Returns {overflow, result}; on overflow the clamp direction follows the sign of a.
    function automatic logic [WIDTH:0] add_sub(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             sub);
        logic [WIDTH-1:0] res;
        logic             ovf;
        if (sub) begin
            res = a - b;
            ovf = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
        end else begin
            res = a + b;
            ovf = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
        end
        if ((SAT != 0) && ovf) begin
            res = a[WIDTH-1] ? MIN_VAL : MAX_VAL;
        end
        return {ovf, res};
    endfunction

    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_mode;
    logic [STAGES-1:0] r_ovf;
    logic [WIDTH-1:0]  r_xm  [STAGES];
    logic [WIDTH-1:0]  r_ym  [STAGES];
    logic [WIDTH-1:0]  r_xr  [STAGES];
    logic [WIDTH-1:0]  r_yr  [STAGES];
    logic [STAGES-1:0] r_dir [STAGES];
    logic [TAG_W-1:0]  r_tag [STAGES];

    logic [STAGES-1:0] w_src_valid;
    logic [STAGES-1:0] w_src_mode;
    logic [STAGES-1:0] w_src_ovf;
    logic [WIDTH-1:0]  w_src_xm  [STAGES];
    logic [WIDTH-1:0]  w_src_ym  [STAGES];
    logic [WIDTH-1:0]  w_src_xr  [STAGES];
    logic [WIDTH-1:0]  w_src_yr  [STAGES];
    logic [STAGES-1:0] w_src_dir [STAGES];
    logic [TAG_W-1:0]  w_src_tag [STAGES];

    logic [STAGES-1:0] w_d;
    logic [STAGES-1:0] w_ovf_nxt;
    logic [WIDTH:0]    w_xs      [STAGES];
    logic [WIDTH:0]    w_ys      [STAGES];
    logic [STAGES-1:0] w_dir_nxt [STAGES];

    logic w_en;
    logic w_unused_mode;

    assign w_en          = out_ready | ~out_valid;
    assign in_ready      = w_en;
    assign w_unused_mode = r_mode[STAGES-1];

    // Stage 0 consumes the input port, every later stage its predecessor's registers.
    always_comb begin
        w_src_valid[0] = in_valid;
        w_src_mode[0]  = mode;
        w_src_ovf[0]   = 1'b0;
        w_src_xm[0]    = xm;
        w_src_ym[0]    = ym;
        w_src_xr[0]    = xr;
        w_src_yr[0]    = yr;
        w_src_dir[0]   = dir_in;
        w_src_tag[0]   = tag_in;
        for (int k = 1; k < STAGES; k++) begin
            w_src_valid[k] = r_valid[k-1];
            w_src_mode[k]  = r_mode[k-1];
            w_src_ovf[k]   = r_ovf[k-1];
            w_src_xm[k]    = r_xm[k-1];
            w_src_ym[k]    = r_ym[k-1];
            w_src_xr[k]    = r_xr[k-1];
            w_src_yr[k]    = r_yr[k-1];
            w_src_dir[k]   = r_dir[k-1];
            w_src_tag[k]   = r_tag[k-1];
        end
    end

    always_comb begin
        w_d       = '0;
        w_ovf_nxt = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_d[k]         = w_src_mode[k] ? ~w_src_ym[k][WIDTH-1]
                                           : w_src_dir[k][STAGES-1-k];
            // d=1: XM + YR, YM - XR; d=0: XM - YR, YM + XR (pre-shift R values).
            w_xs[k]        = add_sub(w_src_xm[k], w_src_yr[k], ~w_d[k]);
            w_ys[k]        = add_sub(w_src_ym[k], w_src_xr[k], w_d[k]);
            w_ovf_nxt[k]   = w_src_ovf[k] | w_xs[k][WIDTH] | w_ys[k][WIDTH];
            w_dir_nxt[k]   = w_src_dir[k];
            w_dir_nxt[k][STAGES-1-k] = w_d[k];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_mode  <= '0;
            r_ovf   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_xm[k]  <= '0;
                r_ym[k]  <= '0;
                r_xr[k]  <= '0;
                r_yr[k]  <= '0;
                r_dir[k] <= '0;
                r_tag[k] <= '0;
            end
        end else if (w_en) begin
            r_valid <= w_src_valid;
            r_mode  <= w_src_mode;
            r_ovf   <= w_ovf_nxt;
            for (int k = 0; k < STAGES; k++) begin
                r_xm[k]  <= w_xs[k][WIDTH-1:0];
                r_ym[k]  <= w_ys[k][WIDTH-1:0];
                r_xr[k]  <= $signed(w_src_xr[k]) >>> 1;
                r_yr[k]  <= $signed(w_src_yr[k]) >>> 1;
                r_dir[k] <= w_dir_nxt[k];
                r_tag[k] <= w_src_tag[k];
            end
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign x_out     = r_xm[STAGES-1];
    assign y_out     = r_ym[STAGES-1];
    assign xr_out    = r_xr[STAGES-1];
    assign yr_out    = r_yr[STAGES-1];
    assign dir_out   = r_dir[STAGES-1];
    assign tag_out   = r_tag[STAGES-1];
    assign ovf_out   = r_ovf[STAGES-1];

endmodule

// File: tb/tb_cordic_pipe_param.sv
// Directed bench for cordic_pipe_param: wrap and saturating instances share one stimulus.
module tb_cordic_pipe_param;

    localparam int W  = 16;
    localparam int S  = 7;
    localparam int T  = 10;
    localparam int RW = 4*W + S + 1;

    // {x_out, y_out, xr_out, yr_out, dir_out, ovf_out}
    localparam logic [RW-1:0] EXP_ROT     = {16'h01FC, 16'hFE04, 16'h0002, 16'h0002, 7'h7F, 1'b0};
    localparam logic [RW-1:0] EXP_VEC     = {16'h0000, 16'hFFFC, 16'h0002, 16'h0000,
                                             7'b1100000, 1'b0};
    localparam logic [RW-1:0] EXP_OVF     = {16'h82F8, 16'h0000, 16'h0000, 16'h0004, 7'h7F, 1'b1};
    localparam logic [RW-1:0] EXP_OVF_SAT = {16'h7FFF, 16'h0000, 16'h0000, 16'h0004, 7'h7F, 1'b1};

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready, in_ready_s;
    logic          mode;
    logic [W-1:0]  xm, ym, xr, yr;
    logic [S-1:0]  dir_in;
    logic [T-1:0]  tag_in;
    logic          out_valid, out_valid_s;
    logic          out_ready;
    logic [W-1:0]  x_out, y_out, xr_out, yr_out;
    logic [W-1:0]  x_out_s, y_out_s, xr_out_s, yr_out_s;
    logic [S-1:0]  dir_out, dir_out_s;
    logic [T-1:0]  tag_out, tag_out_s;
    logic          ovf_out, ovf_out_s;
    logic [RW-1:0] got, got_s;

    int n_checks = 0;
    int n_fail   = 0;

    assign got   = {x_out, y_out, xr_out, yr_out, dir_out, ovf_out};
    assign got_s = {x_out_s, y_out_s, xr_out_s, yr_out_s, dir_out_s, ovf_out_s};

    cordic_pipe_param #(.WIDTH(W), .STAGES(S), .TAG_W(T), .SAT(0)) u_dut (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .xm(xm), .ym(ym), .xr(xr), .yr(yr), .dir_in(dir_in), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready), .x_out(x_out), .y_out(y_out),
        .xr_out(xr_out), .yr_out(yr_out), .dir_out(dir_out), .tag_out(tag_out),
        .ovf_out(ovf_out)
    );

    cordic_pipe_param #(.WIDTH(W), .STAGES(S), .TAG_W(T), .SAT(1)) u_dut_sat (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .mode(mode),
        .xm(xm), .ym(ym), .xr(xr), .yr(yr), .dir_in(dir_in), .tag_in(tag_in),
        .out_valid(out_valid_s), .out_ready(out_ready), .x_out(x_out_s), .y_out(y_out_s),
        .xr_out(xr_out_s), .yr_out(yr_out_s), .dir_out(dir_out_s), .tag_out(tag_out_s),
        .ovf_out(ovf_out_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic set_rot(input logic [T-1:0] t);
        in_valid = 1'b1; mode = 1'b0; dir_in = 7'h7F; tag_in = t;
        xm = 16'h0000; ym = 16'h0000; xr = 16'h0100; yr = 16'h0100;
    endtask

    // dir_in deliberately nonzero: vectoring must ignore it.
    task automatic set_vec(input logic [T-1:0] t);
        in_valid = 1'b1; mode = 1'b1; dir_in = 7'h55; tag_in = t;
        xm = 16'h0000; ym = 16'h0100; xr = 16'h0100; yr = 16'h0000;
    endtask

    task automatic set_ovf(input logic [T-1:0] t);
        in_valid = 1'b1; mode = 1'b0; dir_in = 7'h7F; tag_in = t;
        xm = 16'h7F00; ym = 16'h0000; xr = 16'h0000; yr = 16'h0200;
    endtask

    // Cycles from the presenting negedge until out_valid, bounded.
    task automatic wait_out(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            cyc++;
        end while (!out_valid && cyc < 30);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++;
        if (out_valid !== 1'b0 || got !== '0 || tag_out !== '0)
            $display("FAIL reset_outputs got=%b/%h/%h exp=0/0/0", out_valid, got, tag_out);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_release got=rdy%b vld%b exp=rdy1 vld0", in_ready, out_valid);
    endtask

    task automatic test_rotation();
        int cyc;
        @(negedge clk);
        out_ready = 1'b1;
        set_rot(10'h155);
        wait_out(cyc);
        n_checks++;
        if (cyc !== S) begin n_fail++; $display("FAIL rot_latency got=%0d exp=%0d", cyc, S); end
        n_checks++;
        if (got !== EXP_ROT) begin n_fail++; $display("FAIL rot_data got=%h exp=%h", got, EXP_ROT); end
        n_checks++;
        if (tag_out !== 10'h155) begin
            n_fail++; $display("FAIL rot_tag got=%h exp=155", tag_out);
        end
        n_checks++;
        if (got_s !== EXP_ROT) begin
            n_fail++; $display("FAIL rot_sat_data got=%h exp=%h", got_s, EXP_ROT);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rot_single got=1 exp=0"); end
    endtask

    task automatic test_vectoring();
        int cyc;
        @(negedge clk);
        set_vec(10'h02A);
        wait_out(cyc);
        n_checks++;
        if (cyc !== S) begin n_fail++; $display("FAIL vec_latency got=%0d exp=%0d", cyc, S); end
        n_checks++;
        if (got !== EXP_VEC) begin n_fail++; $display("FAIL vec_data got=%h exp=%h", got, EXP_VEC); end
        n_checks++;
        if (tag_out !== 10'h02A) begin n_fail++; $display("FAIL vec_tag got=%h exp=02a", tag_out); end
    endtask

    task automatic test_overflow();
        int cyc;
        @(negedge clk);
        set_ovf(10'h3FF);
        wait_out(cyc);
        n_checks++;
        if (got !== EXP_OVF) begin n_fail++; $display("FAIL ovf_wrap got=%h exp=%h", got, EXP_OVF); end
        n_checks++;
        if (got_s !== EXP_OVF_SAT) begin
            n_fail++; $display("FAIL ovf_sat got=%h exp=%h", got_s, EXP_OVF_SAT);
        end
    endtask

    task automatic test_back_to_back();
        int exp_idx = 0;
        int first   = -1;
        for (int c = 0; c < 8 + S + 4; c++) begin
            @(negedge clk);
            if (c < 8) begin
                if (c % 2 == 0) set_rot(c[T-1:0]);
                else            set_vec(c[T-1:0]);
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid) begin
                n_checks++;
                if (tag_out !== exp_idx[T-1:0] ||
                    got !== ((exp_idx % 2 == 0) ? EXP_ROT : EXP_VEC)) begin
                    n_fail++;
                    $display("FAIL mixed_result got=%h/%h exp_idx=%0d", tag_out, got, exp_idx);
                end
                if (first < 0) first = c;
                exp_idx++;
            end
        end
        n_checks++;
        if (exp_idx !== 8 || first !== S) begin
            n_fail++; $display("FAIL mixed_count got=%0d@%0d exp=8@%0d", exp_idx, first, S);
        end
    endtask

    task automatic test_backpressure();
        int sent       = 0;
        int got_n      = 0;
        int stall_left = 0;
        int cyc        = 0;
        bit stall_done = 1'b0;
        logic [RW+T:0] snap = '0;
        out_ready = 1'b1;
        while (got_n < 10 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (out_valid && !stall_done) begin
                stall_done = 1'b1;
                stall_left = 5;
                snap = {out_valid, got, tag_out};
            end
            out_ready = (stall_left == 0);
            if (sent < 10) begin
                if (sent % 2 == 0) set_rot(sent[T-1:0]);
                else               set_vec(sent[T-1:0]);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stall_left > 0) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++; $display("FAIL stall_in_ready got=%b exp=0", in_ready);
                end
                n_checks++;
                if ({out_valid, got, tag_out} !== snap) begin
                    n_fail++;
                    $display("FAIL stall_hold got=%h exp=%h", {out_valid, got, tag_out}, snap);
                end
                stall_left--;
            end else if (out_valid) begin
                n_checks++;
                if (tag_out !== got_n[T-1:0] ||
                    got !== ((got_n % 2 == 0) ? EXP_ROT : EXP_VEC)) begin
                    n_fail++;
                    $display("FAIL bp_result got=%h/%h exp_tag=%0d", tag_out, got, got_n);
                end
                got_n++;
            end
            if (in_valid && in_ready) sent++;
        end
        n_checks++;
        if (got_n !== 10 || sent !== 10) begin
            n_fail++; $display("FAIL bp_count got=%0d/%0d exp=10/10", got_n, sent);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_duplicate got=1 exp=0"); end
    endtask

    task automatic test_reset_midop();
        int cyc;
        int stale = 0;
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            set_rot(i[T-1:0]);
        end
        cyc = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            cyc++;
        end while (!out_valid && cyc < 30);
        n_checks++;
        if (out_valid !== 1'b1 || tag_out !== 10'd1) begin
            n_fail++; $display("FAIL midop_inflight got=%b/%h exp=1/001", out_valid, tag_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || got !== '0 || tag_out !== '0) begin
            n_fail++;
            $display("FAIL midop_async_clear got=%b/%h/%h exp=0/0/0", out_valid, got, tag_out);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        n_checks++;
        if (stale !== 0) begin n_fail++; $display("FAIL midop_stale got=%0d exp=0", stale); end
        set_vec(10'h3C3);
        wait_out(cyc);
        n_checks++;
        if (cyc !== S || tag_out !== 10'h3C3 || got !== EXP_VEC) begin
            n_fail++;
            $display("FAIL midop_new got=%0d/%h/%h exp=%0d/3c3/%h", cyc, tag_out, got, S, EXP_VEC);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0;
        xm = '0; ym = '0; xr = '0; yr = '0; dir_in = '0; tag_in = '0;
        test_reset();
        test_rotation();
        test_vectoring();
        test_overflow();
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
